// File: rtl/contador_ajuste_multi_if.sv
// contador_ajuste_multi_if: button/limit inputs and display/write-back outputs
// of the multi-field setting counter. The master drives the buttons and limits;
// the slave (the counter) returns the field values, selection and change pulse.
interface contador_ajuste_multi_if #(
  parameter int WIDTH   = 7,
  parameter int NFIELDS = 3,
  parameter int SELW    = 2
);
  logic                     en;
  logic                     w_r;
  logic                     up;
  logic                     down;
  logic                     left;
  logic                     right;
  logic [NFIELDS*WIDTH-1:0] max_flat;
  logic [NFIELDS*WIDTH-1:0] count_flat;
  logic [SELW-1:0]          sel;
  logic                     changed;

  modport master (
    output en, w_r, up, down, left, right, max_flat,
    input  count_flat, sel, changed
  );

  modport slave (
    input  en, w_r, up, down, left, right, max_flat,
    output count_flat, sel, changed
  );
endinterface

// File: rtl/contador_ajuste_multi.sv
// contador_ajuste_multi: NFIELDS independent wrap-around setting counters with
// per-field run-time limits, stepped by up/down and selected by left/right.
// Buttons are edge-detected on the en scan tick; w_r clears everything.
// Optional feature: define CONTADOR_AUTOREPEAT_EN to auto-repeat a held
// up or down button (REPEAT_DELAY ticks, then every REPEAT_RATE ticks).
module contador_ajuste_multi #(
  parameter int WIDTH        = 7,
  parameter int NFIELDS      = 3,
  parameter int SELW         = 2,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input logic                  clk,
  input logic                  rst,
  contador_ajuste_multi_if.slave bus
);

  typedef logic [WIDTH-1:0] field_t;

  // Button history order: {up, down, left, right}
  localparam int B_UP = 3, B_DN = 2, B_LT = 1, B_RT = 0;

  field_t          count_q [NFIELDS];
  field_t          count_d [NFIELDS];
  logic [SELW-1:0] sel_q, sel_d;
  logic            changed_q, changed_d;
  logic [3:0]      hist_q, hist_d;
  logic [3:0]      btn, press;
  logic            rpt_up, rpt_dn;

  function automatic field_t step_up(field_t c, field_t m);
    return (c >= m) ? '0 : field_t'(c + 1'b1);
  endfunction

  function automatic field_t step_dn(field_t c, field_t m);
    return (c == '0 || c > m) ? m : field_t'(c - 1'b1);
  endfunction

  assign btn   = {bus.up, bus.down, bus.left, bus.right};
  assign press = btn & ~hist_q & {4{bus.en}};

`ifdef CONTADOR_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_cnt_nx;
  logic             rpt_arm_q, rpt_arm_d;
  logic             rpt_fast_q, rpt_fast_d;

  // Repeat timer: armed by a lone up/down press, fires while that button stays held alone
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rpt_cnt_d  = rpt_cnt_q;
    rpt_arm_d  = rpt_arm_q;
    rpt_fast_d = rpt_fast_q;
    rpt_cnt_nx = rpt_cnt_q + 1'b1;
    rpt_up     = 1'b0;
    rpt_dn     = 1'b0;
    if (bus.w_r) begin
      rpt_cnt_d  = '0;
      rpt_arm_d  = 1'b0;
      rpt_fast_d = 1'b0;
    end else if (bus.en) begin
      if ((press[B_UP] && !bus.down) || (press[B_DN] && !bus.up)) begin
        rpt_cnt_d  = '0;
        rpt_arm_d  = 1'b1;
        rpt_fast_d = 1'b0;
      end else if (rpt_arm_q && (bus.up ^ bus.down)) begin
        if (rpt_cnt_nx == (rpt_fast_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY))) begin
          rpt_up     = bus.up;
          rpt_dn     = bus.down;
          rpt_cnt_d  = '0;
          rpt_fast_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_nx;
        end
      end else begin
        rpt_cnt_d  = '0;
        rpt_arm_d  = 1'b0;
        rpt_fast_d = 1'b0;
      end
    end
  end

  // Repeat timer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q  <= '0;
      rpt_arm_q  <= 1'b0;
      rpt_fast_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_arm_q  <= rpt_arm_d;
      rpt_fast_q <= rpt_fast_d;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  // Next field values, selection and change pulse
  always_comb begin
    logic do_up, do_dn, do_rt, do_lt;
    count_d   = count_q;
    sel_d     = sel_q;
    hist_d    = bus.en ? btn : hist_q;
    changed_d = 1'b0;
    do_up     = (press[B_UP] && !press[B_DN]) || rpt_up;
    do_dn     = (press[B_DN] && !press[B_UP]) || rpt_dn;
    do_rt     = press[B_RT] && !press[B_LT];
    do_lt     = press[B_LT] && !press[B_RT];
    if (bus.w_r) begin
      for (int i = 0; i < NFIELDS; i++) count_d[i] = '0;
      sel_d = '0;
    end else begin
      for (int i = 0; i < NFIELDS; i++) begin
        if (sel_q == SELW'(i)) begin
          if (do_up)      count_d[i] = step_up(count_q[i], bus.max_flat[i*WIDTH +: WIDTH]);
          else if (do_dn) count_d[i] = step_dn(count_q[i], bus.max_flat[i*WIDTH +: WIDTH]);
        end
      end
      if (do_rt)      sel_d = (sel_q == SELW'(NFIELDS - 1)) ? '0 : SELW'(sel_q + 1'b1);
      else if (do_lt) sel_d = (sel_q == '0) ? SELW'(NFIELDS - 1) : SELW'(sel_q - 1'b1);
    end
    for (int i = 0; i < NFIELDS; i++) begin
      if (count_d[i] != count_q[i]) changed_d = 1'b1;
    end
  end

  // State register; history resets to 1 so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the field array is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < NFIELDS; i++) count_q[i] <= '0;
      sel_q     <= '0;
      changed_q <= 1'b0;
      hist_q    <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      count_q   <= count_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
      hist_q    <= hist_d;
    end
  end

  // Pack field values onto the flat output bus
  always_comb begin
    bus.count_flat = '0;
    for (int i = 0; i < NFIELDS; i++) bus.count_flat[i*WIDTH +: WIDTH] = count_q[i];
  end

  assign bus.sel     = sel_q;
  assign bus.changed = changed_q;

endmodule

// File: doc/contador_ajuste_multi.md
# contador_ajuste_multi

Parametrised multi-field setting counter for the user-adjust path of the clock/date interface. Holds NFIELDS independent wrap-around counters (e.g. seconds/minutes/hours or day/month/year), each with its own run-time limit. Debounced up/down buttons step the selected field; left/right buttons move the selection. Outputs feed the display formatter and the write-back path to the RTC.

## Interface
- WIDTH, 7, bit width of each field counter
- NFIELDS, 3, number of independent field counters (≥2)
- SELW, 2, width of field selector (≥ clog2(NFIELDS))
- REPEAT_DELAY, 50, en ticks a button must be held before auto-repeat starts
- REPEAT_RATE, 10, en ticks between auto-repeat steps
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  sample strobe (button-scan tick), one clk wide
- w_r  in  1  synchronous clear/hold: 1 = RTC transfer in progress
- up  in  1  increment button, debounced level
- down  in  1  decrement button, debounced level
- left  in  1  select previous field, debounced level
- right  in  1  select next field, debounced level
- max_flat  in  NFIELDS*WIDTH  per-field limit; field i at [i*WIDTH +: WIDTH]
- count_flat  out  NFIELDS*WIDTH  field values, same packing
- sel  out  SELW  index of field under adjustment
- changed  out  1  one-clk pulse when any field value changes

## Operation
- Buttons sampled only on cycles with en=1; a press = sample 1 with previous en-sample 0 (per button).
- Up press on field sel: count ≥ max → 0, else count+1.
- Down press on field sel: count = 0 or count > max → max, else count−1.
- Up and down pressed in the same sample: no step, no changed pulse.
- Right press: sel = NFIELDS−1 → 0, else sel+1. Left press: sel = 0 → NFIELDS−1, else sel−1. Left and right together: sel unchanged.
- Value step and selector move in the same sample: step applies to the old sel field, then sel moves.
- Limit lowered below current value: value kept until next step, which applies the rules above.
- Unselected fields never change except by w_r or reset.
- w_r=1 (regardless of en): all fields ← 0, sel ← 0, repeat state cleared; button history still updated on en so a button held across w_r release does not step.

## Timing
- Reset (rst=0, async): count_flat = 0, sel = 0, changed = 0, button history = 1 (held button at reset release produces no step), repeat counters 0.
- Step latency: field/sel update at the clk edge ending the en cycle that detects the press; changed asserted for that same single cycle.
- No step/select action on cycles with en=0.
- Arithmetic is unsigned WIDTH-bit; no carry between fields.
- w_r takes priority over all button actions in the same cycle.

## Configuration
- CONTADOR_AUTOREPEAT_EN defined: while exactly one of up/down is held alone, after REPEAT_DELAY en ticks following the press a repeat step occurs, then every REPEAT_RATE en ticks; each repeat obeys the same wrap rules and pulses changed. Release, opposite button, w_r or reset clears the repeat counter. Left/right never repeat.
- Undefined: exactly one step per press; no repeat counters synthesised.

## Test plan
- Reset with up held, release rst, 3 en ticks → count_flat = 0, changed never pulses.
- max field0 = 59, field0 = 59, up press → field0 = 0, changed one cycle; down press → 59.
- max field2 = 23, field2 = 30 (lowered limit), down press → 23; up press from 30 → 0.
- sel = 2, right press → sel = 0; left press → sel = 2; up+right same sample at sel=0 → field0 +1, then sel = 1.
- w_r=1 for 1 clk with fields {5,12,7}, sel=1 → all 0, sel 0; up held through w_r release → no step.
- With CONTADOR_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, up held 10 en ticks from field0=0 → values 1 (press), 2 (tick 4), 3 (tick 6), 4 (tick 8); without macro → 1 only.
